// File: rtl/audio_sample_fifo_if.sv
// Sample handshake bundle between the producer/consumer side and the
// audio sample FIFO: write data/request/full and read request/data/empty.
interface audio_sample_fifo_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] wdata_i;
    logic             wr_en_i;
    logic             full_o;
    logic             rd_en_i;
    logic [WIDTH-1:0] rdata_o;
    logic             empty_o;

    // Producer/consumer side: drives requests and write data.
    modport master (
        output wdata_i,
        output wr_en_i,
        output rd_en_i,
        input  full_o,
        input  rdata_o,
        input  empty_o
    );

    // FIFO side: accepts requests, returns status and read data.
    modport slave (
        input  wdata_i,
        input  wr_en_i,
        input  rd_en_i,
        output full_o,
        output rdata_o,
        output empty_o
    );
endinterface

// File: rtl/audio_sample_fifo.sv
// Single-clock audio sample FIFO with occupancy count, live watermarks,
// sticky overflow/underflow flags, synchronous flush and a choice of
// first-word-fall-through or registered read data.
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int FWFT  = 1,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    audio_sample_fifo_if.slave  bus,
    output logic [CNT_W-1:0]    count_o,
    input  logic [CNT_W-1:0]    af_thresh_i,
    input  logic [CNT_W-1:0]    ae_thresh_i,
    output logic                almost_full_o,
    output logic                almost_empty_o,
    output logic                ovf_o,
    output logic                udf_o,
    input  logic                clr_err_i
);

    localparam int ADDR_W = CNT_W - 1;

    // Reject illegal geometries at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("audio_sample_fifo: DEPTH must be a power of two and at least 2");
    end
    if (CNT_W != $clog2(DEPTH) + 1) begin : g_bad_cnt_w
        $error("audio_sample_fifo: CNT_W is derived from DEPTH and must not be overridden");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("audio_sample_fifo: WIDTH must be at least 1");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [CNT_W-1:0]  rptr;
    logic [CNT_W-1:0]  wptr;
    logic [ADDR_W-1:0] raddr;
    logic [ADDR_W-1:0] waddr;
    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              ovf_set;
    logic              udf_set;

    assign raddr = rptr[ADDR_W-1:0];
    assign waddr = wptr[ADDR_W-1:0];

    // The wrap bit distinguishes full from empty when the addresses match.
    assign empty = (rptr == wptr);
    assign full  = (rptr[CNT_W-1] != wptr[CNT_W-1]) && (raddr == waddr);

    // Acceptance is judged on the pre-edge flags; flush discards both requests.
    assign wr_acc  = bus.wr_en_i && !full  && !flush_i;
    assign rd_acc  = bus.rd_en_i && !empty && !flush_i;
    assign ovf_set = bus.wr_en_i &&  full  && !flush_i;
    assign udf_set = bus.rd_en_i &&  empty && !flush_i;

    assign bus.full_o  = full;
    assign bus.empty_o = empty;

    // Occupancy is pointer difference modulo 2*DEPTH; no separate counter.
    assign count_o        = wptr - rptr;
    assign almost_full_o  = (count_o >= af_thresh_i);
    assign almost_empty_o = (count_o <= ae_thresh_i);

    // Sample storage; contents survive flush and reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc) begin
            mem[waddr] <= bus.wdata_i;
        end
    end

    // Read/write pointers; flush returns both to zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr <= '0;
            wptr <= '0;
        end else if (flush_i) begin
            rptr <= '0;
            wptr <= '0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + CNT_W'(1);
            end
            if (rd_acc) begin
                rptr <= rptr + CNT_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_o <= 1'b1;
            end else if (clr_err_i) begin
                ovf_o <= 1'b0;
            end
            if (udf_set) begin
                udf_o <= 1'b1;
            end else if (clr_err_i) begin
                udf_o <= 1'b0;
            end
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head entry is presented combinationally.
        assign bus.rdata_o = mem[raddr];
    end else begin : g_reg_read
        logic [WIDTH-1:0] rdata_q;

        // Head entry is captured on an accepted read and held otherwise.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rdata_q <= '0;
            end else if (rd_acc) begin
                rdata_q <= mem[raddr];
            end
        end

        assign bus.rdata_o = rdata_q;
    end

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Bench for audio_sample_fifo: one FWFT and one registered-read instance
// driven with identical stimulus and compared against a queue-based model.
module tb_audio_sample_fifo;

    localparam int W     = 16;
    localparam int D     = 8;
    localparam int CW    = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic          clr = 1'b0;
    logic          wr = 1'b0;
    logic          rd = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic [CW-1:0] af = CW'(6);
    logic [CW-1:0] ae = CW'(2);

    logic [CW-1:0] count_f, count_r;
    logic          afull_f, afull_r, aempty_f, aempty_r;
    logic          ovf_f, ovf_r, udf_f, udf_r;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;
    logic [W-1:0] m_rreg = '0;

    audio_sample_fifo_if #(.WIDTH(W)) bus_f ();
    audio_sample_fifo_if #(.WIDTH(W)) bus_r ();

    assign bus_f.wdata_i = wdata;
    assign bus_f.wr_en_i = wr;
    assign bus_f.rd_en_i = rd;
    assign bus_r.wdata_i = wdata;
    assign bus_r.wr_en_i = wr;
    assign bus_r.rd_en_i = rd;

    audio_sample_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(1)) dut_f (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush),
        .bus            (bus_f),
        .count_o        (count_f),
        .af_thresh_i    (af),
        .ae_thresh_i    (ae),
        .almost_full_o  (afull_f),
        .almost_empty_o (aempty_f),
        .ovf_o          (ovf_f),
        .udf_o          (udf_f),
        .clr_err_i      (clr)
    );

    audio_sample_fifo #(.WIDTH(W), .DEPTH(D), .FWFT(0)) dut_r (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .flush_i        (flush),
        .bus            (bus_r),
        .count_o        (count_r),
        .af_thresh_i    (af),
        .ae_thresh_i    (ae),
        .almost_full_o  (afull_r),
        .almost_empty_o (aempty_r),
        .ovf_o          (ovf_r),
        .udf_o          (udf_r),
        .clr_err_i      (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances with the model.
    task automatic check_all(input string tag);
        int n;
        n = q.size();
        chk({tag, "/count_f"}, 32'(count_f), n);
        chk({tag, "/count_r"}, 32'(count_r), n);
        chk({tag, "/empty_f"}, 32'(bus_f.empty_o), 32'(n == 0));
        chk({tag, "/empty_r"}, 32'(bus_r.empty_o), 32'(n == 0));
        chk({tag, "/full_f"}, 32'(bus_f.full_o), 32'(n == D));
        chk({tag, "/full_r"}, 32'(bus_r.full_o), 32'(n == D));
        chk({tag, "/afull_f"}, 32'(afull_f), 32'(n >= int'(af)));
        chk({tag, "/afull_r"}, 32'(afull_r), 32'(n >= int'(af)));
        chk({tag, "/aempty_f"}, 32'(aempty_f), 32'(n <= int'(ae)));
        chk({tag, "/aempty_r"}, 32'(aempty_r), 32'(n <= int'(ae)));
        chk({tag, "/ovf_f"}, 32'(ovf_f), 32'(m_ovf));
        chk({tag, "/ovf_r"}, 32'(ovf_r), 32'(m_ovf));
        chk({tag, "/udf_f"}, 32'(udf_f), 32'(m_udf));
        chk({tag, "/udf_r"}, 32'(udf_r), 32'(m_udf));
        if (n > 0) begin
            chk({tag, "/rdata_f"}, 32'(bus_f.rdata_o), 32'(q[0]));
        end
        chk({tag, "/rdata_r"}, 32'(bus_r.rdata_o), 32'(m_rreg));
    endtask

    // One clock cycle: drive at the falling edge, update the model from
    // pre-edge state at the rising edge, then check shortly after.
    task automatic step(input string tag, input logic w, input logic [W-1:0] d,
                        input logic r, input logic f, input logic c);
        logic was_full, was_empty, s_ovf, s_udf;
        @(negedge clk);
        wr = w; wdata = d; rd = r; flush = f; clr = c;
        @(posedge clk);
        was_full  = (q.size() == D);
        was_empty = (q.size() == 0);
        s_ovf = 1'b0;
        s_udf = 1'b0;
        if (f) begin
            q.delete();
        end else begin
            s_ovf = w && was_full;
            s_udf = r && was_empty;
            if (r && !was_empty) begin
                m_rreg = q.pop_front();
            end
            if (w && !was_full) begin
                q.push_back(d);
            end
        end
        if (s_ovf) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (s_udf) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] v;

        // Reset state
        #12;
        check_all("reset_held");
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check_all("reset");

        // Fill and drain
        for (int i = 1; i <= D; i++) begin
            step("fill", 1'b1, W'(i), 1'b0, 1'b0, 1'b0);
        end
        chk("t1_full", 32'(bus_f.full_o), 32'd1);
        chk("t1_count8", 32'(count_f), 32'd8);
        step("fill_ovf", 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        chk("t1_ovf", 32'(ovf_f), 32'd1);
        for (int i = 1; i <= D; i++) begin
            chk("t1_order", 32'(bus_f.rdata_o), 32'(i));
            step("drain", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step("drain_udf", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t1_udf", 32'(udf_f), 32'd1);
        chk("t1_count0", 32'(count_f), 32'd0);
        step("clr_err", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Registered read mode
        step("reg_w1", 1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
        step("reg_w2", 1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
        step("reg_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t2_rdata", 32'(bus_r.rdata_o), 32'h0000A5A5);
        idle("reg_idle1");
        idle("reg_idle2");
        chk("t2_hold", 32'(bus_r.rdata_o), 32'h0000A5A5);
        step("reg_rd2", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("reg_rd_empty", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("t2_hold_empty", 32'(bus_r.rdata_o), 32'h00005A5A);
        step("clr_err2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Simultaneous read/write at count 4, wrapping the pointers
        for (int i = 0; i < 4; i++) begin
            step("sim_fill", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            step("sim_rw", 1'b1, W'($urandom), 1'b1, 1'b0, 1'b0);
        end
        chk("t3_count4", 32'(count_f), 32'd4);

        // Boundaries: both requests at full, then at empty
        while (q.size() < D) begin
            step("to_full", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        step("full_both", 1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        chk("t4_full_cnt", 32'(count_f), 32'd7);
        chk("t4_full_ovf", 32'(ovf_f), 32'd1);
        while (q.size() > 0) begin
            step("to_empty", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step("empty_both", 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);
        chk("t4_empty_cnt", 32'(count_f), 32'd1);
        chk("t4_empty_udf", 32'(udf_f), 32'd1);
        step("clr_err3", 1'b0, '0, 1'b1, 1'b0, 1'b1);

        // Watermarks across all counts, then a live threshold change
        af = CW'(6);
        ae = CW'(2);
        for (int i = 0; i < D; i++) begin
            step("wm_up", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        while (q.size() > 4) begin
            step("wm_down", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        chk("t5_af_before", 32'(afull_f), 32'd0);
        af = CW'(3);
        #1;
        chk("t5_af_live", 32'(afull_f), 32'd1);
        check_all("wm_live");
        af = CW'(0);
        ae = CW'(D);
        #1;
        check_all("wm_extreme");
        af = CW'(6);
        ae = CW'(2);

        // Flush with pending requests and a set overflow flag
        while (q.size() < D) begin
            step("fl_fill", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        step("fl_ovf", 1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("fl_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        end
        step("flush", 1'b1, 16'hCAFE, 1'b1, 1'b1, 1'b0);
        chk("t6_cnt", 32'(count_f), 32'd0);
        chk("t6_ovf", 32'(ovf_f), 32'd1);
        chk("t6_udf", 32'(udf_f), 32'd0);
        step("flush_empty_rd", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        while (q.size() < D) begin
            step("fl_refill", 1'b1, W'($urandom), 1'b0, 1'b0, 1'b0);
        end
        step("clr_vs_set", 1'b1, 16'h7777, 1'b0, 1'b0, 1'b1);
        chk("t6_setwins", 32'(ovf_f), 32'd1);
        step("clr_only", 1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-fill
        step("ar_rd", 1'b0, '0, 1'b1, 1'b0, 1'b0);
        step("ar_wr", 1'b1, 16'h4242, 1'b0, 1'b0, 1'b0);
        step("ar_ovf", 1'b1, 16'h4343, 1'b0, 1'b0, 1'b0);
        #2;
        rst_ni = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_rreg = '0;
        chk("t6_async_cnt", 32'(count_f), 32'd0);
        check_all("async_rst");
        @(negedge clk);
        rst_ni = 1'b1;
        wr = 1'b0; rd = 1'b0; flush = 1'b0; clr = 1'b0;
        #1;
        check_all("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic rw, rr, rf, rc;
            rw = ($urandom_range(0, 99) < 55);
            rr = ($urandom_range(0, 99) < 50);
            rf = ($urandom_range(0, 99) < 3);
            rc = ($urandom_range(0, 99) < 8);
            v  = W'($urandom);
            if ((i % 37) == 0) begin
                af = CW'($urandom_range(0, 15));
                ae = CW'($urandom_range(0, 15));
            end
            step("rand", rw, v, rr, rf, rc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
